// File: rtl/room_controller_pkg.sv
// Shared types and map geometry for the room controller and its neighbour lookup.
package room_controller_pkg;

  typedef enum logic [2:0] {
    DOOR_NONE  = 3'd0,
    DOOR_EAST  = 3'd1,
    DOOR_WEST  = 3'd2,
    DOOR_NORTH = 3'd3,
    DOOR_SOUTH = 3'd4
  } door_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } state_e;

  localparam int         MAP_COLS = 3;
  localparam int         MAP_ROWS = 2;
  localparam logic [2:0] FADE_MAX = 3'd7;

endpackage

// File: rtl/room_controller_room_map.sv
// Combinational neighbour lookup on the 3x2 room grid; rooms off the grid have no exits.
module room_map
  import room_controller_pkg::*;
(
  input  logic [2:0] room,
  input  logic [2:0] doorcode,
  output logic [2:0] next_room,
  output logic       valid
);

  localparam logic [2:0] COLS  = 3'(MAP_COLS);
  localparam logic [2:0] ROOMS = 3'(MAP_ROWS * MAP_COLS);

  logic       on_map;
  logic       row1;
  logic [2:0] col;

  always_comb begin
    next_room = room;
    valid     = 1'b0;
    on_map    = (room < ROOMS);
    row1      = (room >= COLS);
    col       = row1 ? (room - COLS) : room;
    if (on_map) begin
      case (doorcode)
        DOOR_EAST:  if (col < COLS - 3'd1) begin next_room = room + 3'd1; valid = 1'b1; end
        DOOR_WEST:  if (col != 3'd0)       begin next_room = room - 3'd1; valid = 1'b1; end
        DOOR_NORTH: if (row1)              begin next_room = room - COLS; valid = 1'b1; end
        DOOR_SOUTH: if (!row1)             begin next_room = room + COLS; valid = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/room_controller.sv
// Room sequencer: accepts exits on frame ticks and swaps rooms, optionally with a
// fade-out/fade-in around the swap when ROOM_FADE_EN is defined.
module room_controller
  import room_controller_pkg::*;
#(
  parameter logic [2:0] START_ROOM       = 3'd0,
  parameter int         FADE_STEP_FRAMES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] doorcode,
  output logic [2:0] room,
  output logic [2:0] fade_level,
  output logic       busy
);

  if (FADE_STEP_FRAMES < 1 || FADE_STEP_FRAMES > 15) begin : g_bad_step
    $error("FADE_STEP_FRAMES out of range 1..15");
  end

  state_e     state_reg, state_next;
  logic [2:0] room_reg, target_reg;
  logic       frame_d_reg;
  logic       frame_edge;
  logic [2:0] map_next;
  logic       map_valid;

  assign frame_edge = frame_clk & ~frame_d_reg;

  room_map u_room_map (
    .room      (room_reg),
    .doorcode  (doorcode),
    .next_room (map_next),
    .valid     (map_valid)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_d_reg <= 1'b0;
      state_reg   <= IDLE;
      room_reg    <= START_ROOM;
      target_reg  <= 3'd0;
    end else begin
      frame_d_reg <= frame_clk;
      state_reg   <= state_next;
      if (state_reg == IDLE && frame_edge && map_valid)
        target_reg <= map_next;
      if (state_reg == SWAP)
        room_reg <= target_reg;
    end
  end

`ifdef ROOM_FADE_EN
  localparam logic [3:0] STEP_LAST = 4'(FADE_STEP_FRAMES - 1);

  logic [3:0] step_reg, step_next;
  logic [2:0] level_reg, level_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_reg  <= 4'd0;
      level_reg <= 3'd0;
    end else begin
      step_reg  <= step_next;
      level_reg <= level_next;
    end
  end

  // Levels move only on the last frame tick of each step; the saturation guards keep them in 0..7.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    level_next = level_reg;
    case (state_reg)
      IDLE: begin
        if (frame_edge && map_valid) begin
          state_next = FADE_OUT;
          step_next  = 4'd0;
        end
      end
      FADE_OUT: begin
        if (frame_edge) begin
          if (step_reg >= STEP_LAST && level_reg != FADE_MAX) begin
            step_next  = 4'd0;
            level_next = level_reg + 3'd1;
            if (level_next == FADE_MAX) state_next = SWAP;
          end else begin
            step_next = step_reg + 4'd1;
          end
        end
      end
      SWAP: begin
        state_next = FADE_IN;
        step_next  = 4'd0;
      end
      FADE_IN: begin
        if (frame_edge) begin
          if (step_reg >= STEP_LAST && level_reg != 3'd0) begin
            step_next  = 4'd0;
            level_next = level_reg - 3'd1;
            if (level_next == 3'd0) state_next = IDLE;
          end else begin
            step_next = step_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fade_level = level_reg;
`else
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_edge && map_valid) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fade_level = 3'd0;
`endif

  assign room = room_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_room_controller.sv
// Two controllers (step 1 and step 3 frames) share stimulus; each is tracked by a
// frame-counting reference model and compared every clock.
module tb_room_controller;

`ifdef ROOM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif
  localparam int F0 = 1;
  localparam int F1 = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [2:0] doorcode;
  logic [2:0] room_o [2];
  logic [2:0] fade_o [2];
  logic       busy_o [2];

  always #5 Clk = ~Clk;

  room_controller #(.START_ROOM(3'd0), .FADE_STEP_FRAMES(F0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .doorcode(doorcode),
    .room(room_o[0]), .fade_level(fade_o[0]), .busy(busy_o[0]));

  room_controller #(.START_ROOM(3'd0), .FADE_STEP_FRAMES(F1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .doorcode(doorcode),
    .room(room_o[1]), .fade_level(fade_o[1]), .busy(busy_o[1]));

  int errors = 0;
  int checks = 0;
  int nprint = 0;

  // Reference model state: a transition is tracked by frame ticks counted per half.
  int fsteps [2] = '{F0, F1};
  int m_room [2];
  int m_target [2];
  int m_edges [2];
  bit m_busy [2];
  bit m_swap [2];
  bit m_half [2];
  bit m_fd;

  typedef struct {
    int door;
    int exp_room;
  } vec_t;
  vec_t tbl [17];

  // Hand-written exit list for the 3x2 grid; -1 means no exit.
  function automatic int nb(int r, int d);
    case (r)
      0: case (d) 1: return 1; 4: return 3; default: return -1; endcase
      1: case (d) 1: return 2; 2: return 0; 4: return 4; default: return -1; endcase
      2: case (d) 2: return 1; 4: return 5; default: return -1; endcase
      3: case (d) 1: return 4; 3: return 0; default: return -1; endcase
      4: case (d) 1: return 5; 2: return 3; 3: return 1; default: return -1; endcase
      5: case (d) 2: return 4; 3: return 2; default: return -1; endcase
      default: return -1;
    endcase
  endfunction

  function automatic int model_level(int i);
    if (!FADE || !m_busy[i]) return 0;
    if (m_swap[i]) return 7;
    if (!m_half[i]) return m_edges[i] / fsteps[i];
    return 7 - m_edges[i] / fsteps[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_room[i] = 0; m_target[i] = 0; m_edges[i] = 0;
      m_busy[i] = 0; m_swap[i] = 0; m_half[i] = 0;
    end
    m_fd = 0;
  endtask

  task automatic model_step(input bit fc, input int dc);
    bit fe;
    int t;
    fe = fc && !m_fd;
    m_fd = fc;
    for (int i = 0; i < 2; i++) begin
      if (m_swap[i]) begin
        m_room[i] = m_target[i];
        m_swap[i] = 0;
        if (FADE) begin m_half[i] = 1; m_edges[i] = 0; end
        else m_busy[i] = 0;
      end else if (!m_busy[i]) begin
        t = nb(m_room[i], dc);
        if (fe && t >= 0) begin
          m_busy[i] = 1;
          m_target[i] = t;
          if (FADE) begin m_half[i] = 0; m_edges[i] = 0; end
          else m_swap[i] = 1;
        end
      end else if (fe) begin
        m_edges[i]++;
        if (m_edges[i] == 7 * fsteps[i]) begin
          if (!m_half[i]) m_swap[i] = 1;
          else m_busy[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d room", i), int'(room_o[i]), m_room[i]);
      check($sformatf("dut%0d fade_level", i), int'(fade_o[i]), model_level(i));
      check($sformatf("dut%0d busy", i), int'(busy_o[i]), int'(m_busy[i]));
    end
  endtask

  task automatic cycle(input bit fc, input int dc);
    @(negedge Clk);
    frame_clk = fc;
    doorcode  = dc[2:0];
    model_step(fc, dc);
    @(posedge Clk);
    #1;
    check_all();
  endtask

  // One frame period: two low cycles, then a rising frame_clk held for two cycles.
  task automatic frame(input int dc);
    cycle(1'b0, dc); cycle(1'b0, dc); cycle(1'b1, dc); cycle(1'b1, dc);
  endtask

  // Doorcode stays asserted while both controllers are busy, so it must be ignored.
  task automatic txn(input int dc, input int exp_room);
    int n = 0;
    frame(dc);
    while ((m_busy[0] || m_busy[1]) && n < 100) begin
      frame((m_busy[0] && m_busy[1]) ? dc : 0);
      n++;
    end
    if (n >= 100) check("txn timeout", n, 0);
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d table room", i), int'(room_o[i]), exp_room);
    $display("txn door=%0d room0=%0d room1=%0d frames=%0d", dc, room_o[0], room_o[1], n);
  endtask

  task automatic async_reset();
    @(negedge Clk);
    frame_clk = 1'b0;
    doorcode  = 3'd0;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    tbl = '{'{3, 0}, '{2, 0}, '{1, 1}, '{4, 4}, '{3, 1}, '{5, 1}, '{1, 2}, '{1, 2},
            '{4, 5}, '{4, 5}, '{2, 4}, '{2, 3}, '{2, 3}, '{3, 0}, '{0, 0}, '{7, 0}, '{6, 0}};

    Reset = 1'b1;
    frame_clk = 1'b0;
    doorcode = 3'd0;
    model_reset();
    @(negedge Clk);
    @(posedge Clk);
    #1;
    check_all();
    @(negedge Clk);
    Reset = 1'b0;

    for (int k = 0; k < 17; k++)
      txn(tbl[k].door, tbl[k].exp_room);

    // Reset in the middle of a transition from room 0 heading east.
    cycle(1'b0, 1); cycle(1'b0, 1); cycle(1'b1, 1);
    n = 0;
    while (FADE && model_level(0) != 4 && n < 20) begin
      frame(0);
      n++;
    end
    check("reset-mid setup busy", int'(busy_o[0]), 1);
    async_reset();
    $display("txn reset-mid room0=%0d fade0=%0d busy0=%0d", room_o[0], fade_o[0], busy_o[0]);
    cycle(1'b0, 0);

    for (int k = 0; k < 3000; k++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    $display("txn random room0=%0d room1=%0d", room_o[0], room_o[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
